// File: rtl/drive_cmd_decoder.sv
// Single-byte drive command decoder with trim pulse generator and link-loss watchdog.
// Optional echo of accepted bytes to UART TX when CMD_ECHO_EN is defined.
module drive_cmd_decoder #(
    parameter int unsigned TRIM_HOLD   = 1_000_001,
    parameter int unsigned WDOG_CYCLES = 50_000_000
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] drive_mode,
    output logic       trim_plus_n,
    output logic       trim_minus_n,
    output logic [7:0] last_cmd,
    output logic [7:0] err_cnt,
    output logic       wdog_trip,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int unsigned HOLD_W = 21;
    localparam int unsigned WDOG_W = 26;
    localparam logic [1:0]  MODE_STOP = 2'b00;
    localparam logic [1:0]  MODE_FWD  = 2'b01;
    localparam logic [1:0]  MODE_REV  = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD_P, ST_HOLD_M} trim_state_t;

    trim_state_t       state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [WDOG_W-1:0] wdog_cnt, wdog_cnt_nxt;
    logic [1:0]        drive_mode_nxt;
    logic [7:0]        last_cmd_nxt;
    logic [7:0]        err_cnt_nxt;
    logic              wdog_trip_nxt;

    logic is_fwd_c, is_rev_c, is_stop_c, is_plus_c, is_minus_c;
    logic is_mode_c, accept_c;

    // Byte classification; letters match either case
    always_comb begin
        is_fwd_c   = (rx_data == 8'h46) || (rx_data == 8'h66);
        is_rev_c   = (rx_data == 8'h42) || (rx_data == 8'h62);
        is_stop_c  = (rx_data == 8'h53) || (rx_data == 8'h73);
        is_plus_c  = (rx_data == 8'h2B);
        is_minus_c = (rx_data == 8'h2D);
        is_mode_c  = is_fwd_c || is_rev_c || is_stop_c;
        accept_c   = rx_valid && (is_mode_c || is_plus_c || is_minus_c);
    end

    // Next-state for mode, status counters, watchdog and trim FSM
    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        wdog_cnt_nxt   = wdog_cnt;
        drive_mode_nxt = drive_mode;
        last_cmd_nxt   = last_cmd;
        err_cnt_nxt    = err_cnt;
        wdog_trip_nxt  = wdog_trip;

        if (accept_c) begin
            last_cmd_nxt = rx_data;
            wdog_cnt_nxt = '0;
            if (is_mode_c) begin
                wdog_trip_nxt = 1'b0;
                if (is_fwd_c)      drive_mode_nxt = MODE_FWD;
                else if (is_rev_c) drive_mode_nxt = MODE_REV;
                else               drive_mode_nxt = MODE_STOP;
            end
        end else begin
            if (rx_valid && (err_cnt != 8'hFF)) err_cnt_nxt = err_cnt + 8'd1;
            // Expired watchdog holds its count and keeps forcing STOP
            if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                drive_mode_nxt = MODE_STOP;
                wdog_trip_nxt  = 1'b1;
            end else begin
                wdog_cnt_nxt = wdog_cnt + WDOG_W'(1);
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (accept_c && is_plus_c) begin
                    state_nxt    = ST_HOLD_P;
                    hold_cnt_nxt = HOLD_W'(TRIM_HOLD - 1);
                end else if (accept_c && is_minus_c) begin
                    state_nxt    = ST_HOLD_M;
                    hold_cnt_nxt = HOLD_W'(TRIM_HOLD - 1);
                end
            end
            ST_HOLD_P, ST_HOLD_M: begin
                if (hold_cnt == '0) state_nxt = ST_IDLE;
                else                hold_cnt_nxt = hold_cnt - HOLD_W'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            wdog_cnt     <= '0;
            drive_mode   <= MODE_STOP;
            trim_plus_n  <= 1'b1;
            trim_minus_n <= 1'b1;
            last_cmd     <= '0;
            err_cnt      <= '0;
            wdog_trip    <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            wdog_cnt     <= wdog_cnt_nxt;
            drive_mode   <= drive_mode_nxt;
            trim_plus_n  <= (state_nxt != ST_HOLD_P);
            trim_minus_n <= (state_nxt != ST_HOLD_M);
            last_cmd     <= last_cmd_nxt;
            err_cnt      <= err_cnt_nxt;
            wdog_trip    <= wdog_trip_nxt;
        end
    end

`ifdef CMD_ECHO_EN
    // One-entry echo buffer; a new byte overwrites an unsent one
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (accept_c) begin
            tx_data  <= rx_data;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready;
    assign tx_data  = '0;
    assign tx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_drive_cmd_decoder.sv
// Directed bench for drive_cmd_decoder (TRIM_HOLD=8, WDOG_CYCLES=100).
module tb_drive_cmd_decoder;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [1:0] drive_mode;
    logic       trim_plus_n, trim_minus_n;
    logic [7:0] last_cmd, err_cnt, tx_data;
    logic       wdog_trip, tx_valid;
    logic       tx_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic echo_seen = 1'b0;

    drive_cmd_decoder #(.TRIM_HOLD(8), .WDOG_CYCLES(100)) dut (
        .m_clock(m_clock), .p_reset(p_reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .drive_mode(drive_mode), .trim_plus_n(trim_plus_n), .trim_minus_n(trim_minus_n),
        .last_cmd(last_cmd), .err_cnt(err_cnt), .wdog_trip(wdog_trip),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 m_clock = ~m_clock;

    always @(negedge m_clock) if (tx_valid) echo_seen <= 1'b1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [7:0] last;
        logic [7:0] err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks are entered and left at a falling clock edge
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge m_clock);
        rx_valid = 1'b0;
    endtask

    task automatic burst(input logic [7:0] b, input int n);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (n) @(negedge m_clock);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        p_reset = 1'b0;
        repeat (2) @(negedge m_clock);
        p_reset = 1'b1;
        @(negedge m_clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " mode"},  32'(drive_mode), 32'd0);
        check({tag, " tp_n"},  32'(trim_plus_n), 32'd1);
        check({tag, " tm_n"},  32'(trim_minus_n), 32'd1);
        check({tag, " last"},  32'(last_cmd), 32'd0);
        check({tag, " err"},   32'(err_cnt), 32'd0);
        check({tag, " trip"},  32'(wdog_trip), 32'd0);
        check({tag, " txv"},   32'(tx_valid), 32'd0);
        check({tag, " txd"},   32'(tx_data), 32'd0);
    endtask

    vec_t vecs[8];
    int   low_p, low_m;

    initial begin
        vecs[0] = '{8'h46, 2'b01, 8'h46, 8'd0};
        vecs[1] = '{8'h62, 2'b10, 8'h62, 8'd0};
        vecs[2] = '{8'h41, 2'b10, 8'h62, 8'd1};
        vecs[3] = '{8'h73, 2'b00, 8'h73, 8'd1};
        vecs[4] = '{8'h66, 2'b01, 8'h66, 8'd1};
        vecs[5] = '{8'h42, 2'b10, 8'h42, 8'd1};
        vecs[6] = '{8'h7A, 2'b10, 8'h42, 8'd2};
        vecs[7] = '{8'h53, 2'b00, 8'h53, 8'd2};

        @(negedge m_clock);
        do_reset();
        check_reset_vals("reset");

        // Table-driven decode
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data);
            check($sformatf("vec%0d mode", i), 32'(drive_mode), 32'(vecs[i].mode));
            check($sformatf("vec%0d last", i), 32'(last_cmd), 32'(vecs[i].last));
            check($sformatf("vec%0d err", i), 32'(err_cnt), 32'(vecs[i].err));
        end

        // '+' holds trim_plus_n low 8 cycles; '-' during the hold is ignored
        do_reset();
        send(8'h2B);
        low_p = 0;
        low_m = 0;
        for (int i = 0; i < 20; i++) begin
            if (!trim_plus_n) low_p++;
            if (!trim_minus_n) low_m++;
            if (i == 2) begin
                rx_data  = 8'h2D;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge m_clock);
        end
        check("plus low cycles", 32'(low_p), 32'd8);
        check("minus low during plus", 32'(low_m), 32'd0);
        check("err after ignored trim", 32'(err_cnt), 32'd0);
        check("last after ignored trim", 32'(last_cmd), 32'h2D);

        // '-' from idle
        send(8'h2D);
        check("minus active", 32'(trim_minus_n), 32'd0);
        check("plus idle", 32'(trim_plus_n), 32'd1);
        repeat (7) @(negedge m_clock);
        check("minus end of hold", 32'(trim_minus_n), 32'd0);
        @(negedge m_clock);
        check("minus released", 32'(trim_minus_n), 32'd1);

        // err_cnt saturation, watchdog fed by 'B' between bursts
        do_reset();
        for (int r = 0; r < 4; r++) begin
            send(8'h42);
            burst(8'h41, 80);
            if (r == 2) check("err mid", 32'(err_cnt), 32'd240);
        end
        check("err saturated", 32'(err_cnt), 32'd255);
        burst(8'h61, 5);
        check("err stays 255", 32'(err_cnt), 32'd255);
        check("mode during errs", 32'(drive_mode), 32'd2);
        check("no trip during errs", 32'(wdog_trip), 32'd0);

        // Watchdog expiry
        do_reset();
        send(8'h46);
        repeat (99) @(negedge m_clock);
        check("wdog pre-expiry mode", 32'(drive_mode), 32'd1);
        check("wdog pre-expiry trip", 32'(wdog_trip), 32'd0);
        @(negedge m_clock);
        check("wdog expiry mode", 32'(drive_mode), 32'd0);
        check("wdog expiry trip", 32'(wdog_trip), 32'd1);
        repeat (5) @(negedge m_clock);
        check("wdog trip sticky", 32'(wdog_trip), 32'd1);
        send(8'h53);
        check("S clears trip", 32'(wdog_trip), 32'd0);
        check("S last", 32'(last_cmd), 32'h53);

        // Command on the expiry cycle wins
        send(8'h46);
        repeat (99) @(negedge m_clock);
        send(8'h46);
        check("race mode", 32'(drive_mode), 32'd1);
        check("race trip", 32'(wdog_trip), 32'd0);
        @(negedge m_clock);
        check("race no late trip", 32'(wdog_trip), 32'd0);

        // Async reset mid-hold
        send(8'h46);
        send(8'h2B);
        @(negedge m_clock);
        check("hold before reset", 32'(trim_plus_n), 32'd0);
        #2 p_reset = 1'b0;
        #1;
        check_reset_vals("async reset");
        @(negedge m_clock);
        p_reset = 1'b1;
        @(negedge m_clock);

`ifdef CMD_ECHO_EN
        tx_ready = 1'b0;
        send(8'h46);
        send(8'h53);
        check("echo data", 32'(tx_data), 32'h53);
        check("echo valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        @(negedge m_clock);
        tx_ready = 1'b0;
        check("echo drained", 32'(tx_valid), 32'd0);
`else
        tx_ready = 1'b1;
        send(8'h46);
        tx_ready = 1'b0;
        send(8'h53);
        @(negedge m_clock);
        check("no echo valid", 32'(echo_seen), 32'd0);
        check("no echo data", 32'(tx_data), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
